// File: rtl/cache_req_frontend.sv
// cache_req_frontend
//   Request front-end placed directly upstream of the reconfigurable cache.
//   Incoming 76-bit requests are buffered in a small FIFO and dispatched to
//   the cache over val/rdy. The number of requests dispatched but not yet
//   answered is tracked by watching the response handshake. A mode change on
//   reconfig_req is applied only once every in-flight request has drained.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   in_req_msg/val/rdy   upstream request channel
//                        msg = {type[75:74], opaque[73:66], addr[65:34],
//                               len[33:32], data[31:0]}
//   cachereq_msg/val/rdy request channel to the cache (FIFO head)
//   cacheresp_val/rdy    cache response handshake (monitored only)
//   reconfig_req         requested cache mode
//   reconfiguration      registered mode driven to the cache
//   reconfig_busy        high while draining or switching mode
//
// Optional build macro CACHE_REQ_FRONTEND_STATS_EN adds:
//   stat_req_count       saturating count of cache request handshakes
//   stat_drain_cycles    saturating count of cycles spent draining
module cache_req_frontend #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned SETTLE    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [75:0] in_req_msg,
  input  logic        in_req_val,
  output logic        in_req_rdy,
  output logic [75:0] cachereq_msg,
  output logic        cachereq_val,
  input  logic        cachereq_rdy,
  input  logic        cacheresp_val,
  input  logic        cacheresp_rdy,
  input  logic [1:0]  reconfig_req,
  output logic [1:0]  reconfiguration,
  output logic        reconfig_busy
`ifdef CACHE_REQ_FRONTEND_STATS_EN
  ,
  output logic [15:0] stat_req_count,
  output logic [15:0] stat_drain_cycles
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam int unsigned SW = $clog2(SETTLE + 1);

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [OW-1:0] MAX_C     = OW'(MAX_OUTST);
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_SWITCH
  } state_t;

  logic [75:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [OW-1:0] r_outst;
  logic [OW-1:0] w_outst_next;
  logic [SW-1:0] r_settle;
  logic [SW-1:0] w_settle_next;
  logic [1:0]    r_mode;
  state_t        r_state;
  state_t        w_state_next;

  logic w_empty;
  logic w_full;
  logic w_enq;
  logic w_deq;
  logic w_resp;
  logic w_mismatch;
  logic w_mode_load;

  // ---------------- handshake / status decode ----------------
  always_comb begin
    w_empty    = (r_count == '0);
    w_full     = (r_count == DEPTH_C);
    w_mismatch = (reconfig_req != r_mode);

    in_req_rdy    = !reset && !w_full;
    // Dispatch is gated combinationally so a mode mismatch blocks it in the
    // same cycle it appears, before the FSM has left RUN.
    cachereq_val  = !reset && (r_state == ST_RUN) && !w_empty &&
                    (r_outst < MAX_C) && !w_mismatch;
    cachereq_msg  = (reset || w_empty) ? '0 : r_mem[r_rd_ptr];
    reconfig_busy = !reset && (r_state != ST_RUN);
    reconfiguration = r_mode;

    w_enq  = in_req_val && in_req_rdy;
    w_deq  = cachereq_val && cachereq_rdy;
    // Responses arriving with nothing outstanding (e.g. for requests issued
    // before a reset) are absorbed here.
    w_resp = cacheresp_val && cacheresp_rdy && (r_outst != '0);
  end

  // ---------------- request FIFO ----------------
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= in_req_msg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- outstanding counter ----------------
  always_comb begin
    w_outst_next = r_outst;
    case ({w_deq, w_resp})
      2'b10:   w_outst_next = r_outst + 1'b1;
      2'b01:   w_outst_next = r_outst - 1'b1;
      default: w_outst_next = r_outst;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_outst <= '0;
    end else begin
      r_outst <= w_outst_next;
    end
  end

  // ---------------- reconfiguration FSM ----------------
  always_comb begin
    w_state_next  = r_state;
    w_settle_next = r_settle;
    w_mode_load   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_mismatch) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Looking at the next count lets the switch happen on the very edge
        // where the last response handshakes.
        if (w_outst_next == '0) begin
          w_state_next  = ST_SWITCH;
          w_mode_load   = 1'b1;
          w_settle_next = SETTLE_LD;
        end
      end
      ST_SWITCH: begin
        if (r_settle == '0) begin
          w_state_next = ST_RUN;
        end else begin
          w_settle_next = r_settle - 1'b1;
        end
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_RUN;
      r_settle <= '0;
      r_mode   <= '0;
    end else begin
      r_state  <= w_state_next;
      r_settle <= w_settle_next;
      if (w_mode_load) begin
        r_mode <= reconfig_req;
      end
    end
  end

`ifdef CACHE_REQ_FRONTEND_STATS_EN
  // ---------------- statistics ----------------
  logic [15:0] r_stat_req;
  logic [15:0] r_stat_drain;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_req   <= '0;
      r_stat_drain <= '0;
    end else begin
      if (w_deq && (r_stat_req != '1)) begin
        r_stat_req <= r_stat_req + 1'b1;
      end
      if ((r_state == ST_DRAIN) && (r_stat_drain != '1)) begin
        r_stat_drain <= r_stat_drain + 1'b1;
      end
    end
  end

  always_comb begin
    stat_req_count    = r_stat_req;
    stat_drain_cycles = r_stat_drain;
  end
`endif

endmodule

// File: tb/tb_cache_req_frontend.sv
module tb_cache_req_frontend;

  logic        clk;
  logic        reset;
  logic [75:0] in_req_msg;
  logic        in_req_val;
  logic        in_req_rdy;
  logic [75:0] cachereq_msg;
  logic        cachereq_val;
  logic        cachereq_rdy;
  logic        cacheresp_val;
  logic        cacheresp_rdy;
  logic [1:0]  reconfig_req;
  logic [1:0]  reconfiguration;
  logic        reconfig_busy;
`ifdef CACHE_REQ_FRONTEND_STATS_EN
  logic [15:0] stat_req_count;
  logic [15:0] stat_drain_cycles;
`endif

  cache_req_frontend #(
    .DEPTH    (4),
    .MAX_OUTST(4),
    .SETTLE   (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_req_msg     (in_req_msg),
    .in_req_val     (in_req_val),
    .in_req_rdy     (in_req_rdy),
    .cachereq_msg   (cachereq_msg),
    .cachereq_val   (cachereq_val),
    .cachereq_rdy   (cachereq_rdy),
    .cacheresp_val  (cacheresp_val),
    .cacheresp_rdy  (cacheresp_rdy),
    .reconfig_req   (reconfig_req),
    .reconfiguration(reconfiguration),
    .reconfig_busy  (reconfig_busy)
`ifdef CACHE_REQ_FRONTEND_STATS_EN
    ,
    .stat_req_count   (stat_req_count),
    .stat_drain_cycles(stat_drain_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [75:0] msg;
    logic        crdy;
    logic        rv;
    logic        rr;
    logic [1:0]  rq;
    logic        e_irdy;
    logic        e_cval;
    logic [75:0] e_msg;
    logic [1:0]  e_mode;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];
  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  localparam logic [75:0] Z = '0;
  localparam logic [75:0] W = {2'd1, 8'h00, 32'h0, 2'd0, 32'h0a0b0c0d};

  function automatic logic [75:0] mk(input int unsigned i);
    logic [7:0] opq;
    opq = 8'(i);
    return {2'd1, opq, 32'h1000 + 32'(i) * 32'd4, 2'd2, 32'hD000_0000 | 32'(i)};
  endfunction

  function automatic vec_t v(input logic rst, input logic iv, input logic [75:0] msg,
                             input logic crdy, input logic rv, input logic rr,
                             input logic [1:0] rq, input logic e_irdy, input logic e_cval,
                             input logic [75:0] e_msg, input logic [1:0] e_mode,
                             input logic e_busy);
    vec_t t;
    t.rst = rst; t.iv = iv; t.msg = msg; t.crdy = crdy; t.rv = rv; t.rr = rr;
    t.rq = rq; t.e_irdy = e_irdy; t.e_cval = e_cval; t.e_msg = e_msg;
    t.e_mode = e_mode; t.e_busy = e_busy;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [75:0] act, input logic [75:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked 2ns later, well
  // before the next rising edge.
  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    reset         = t.rst;
    in_req_val    = t.iv;
    in_req_msg    = t.msg;
    cachereq_rdy  = t.crdy;
    cacheresp_val = t.rv;
    cacheresp_rdy = t.rr;
    reconfig_req  = t.rq;
    #2;
    chk({tag, ".in_req_rdy"},      76'(in_req_rdy),      76'(t.e_irdy));
    chk({tag, ".cachereq_val"},    76'(cachereq_val),    76'(t.e_cval));
    chk({tag, ".cachereq_msg"},    cachereq_msg,         t.e_msg);
    chk({tag, ".reconfiguration"}, 76'(reconfiguration), 76'(t.e_mode));
    chk({tag, ".reconfig_busy"},   76'(reconfig_busy),   76'(t.e_busy));
  endtask

  initial begin
    reset = 1'b1; in_req_val = 1'b0; in_req_msg = '0; cachereq_rdy = 1'b0;
    cacheresp_val = 1'b0; cacheresp_rdy = 1'b0; reconfig_req = 2'd0;

    //          rst iv msg    crd rv rr rq   irdy cval emsg  mode busy
    // reset, single write, first-dispatch latency
    tbl.push_back(v(1, 0, Z,      0, 0, 0, 0,  0, 0, Z,      0, 0));
    tbl.push_back(v(0, 1, W,      1, 0, 0, 0,  1, 0, Z,      0, 0));
    tbl.push_back(v(0, 0, Z,      1, 0, 0, 0,  1, 1, W,      0, 0));
    tbl.push_back(v(0, 0, Z,      0, 1, 1, 0,  1, 0, Z,      0, 0));
    // backpressure: fill 4, 5th waits, then drain in order
    tbl.push_back(v(0, 1, mk(0),  0, 0, 0, 0,  1, 0, Z,      0, 0));
    tbl.push_back(v(0, 1, mk(1),  0, 0, 0, 0,  1, 1, mk(0),  0, 0));
    tbl.push_back(v(0, 1, mk(2),  0, 0, 0, 0,  1, 1, mk(0),  0, 0));
    tbl.push_back(v(0, 1, mk(3),  0, 0, 0, 0,  1, 1, mk(0),  0, 0));
    tbl.push_back(v(0, 1, mk(4),  0, 0, 0, 0,  0, 1, mk(0),  0, 0));
    tbl.push_back(v(0, 1, mk(4),  1, 0, 0, 0,  0, 1, mk(0),  0, 0));
    tbl.push_back(v(0, 1, mk(4),  1, 0, 0, 0,  1, 1, mk(1),  0, 0));
    tbl.push_back(v(0, 0, Z,      1, 0, 0, 0,  1, 1, mk(2),  0, 0));
    tbl.push_back(v(0, 0, Z,      1, 0, 0, 0,  1, 1, mk(3),  0, 0));
    // outstanding limit reached at 4, one response reopens dispatch
    tbl.push_back(v(0, 0, Z,      1, 0, 0, 0,  1, 0, mk(4),  0, 0));
    tbl.push_back(v(0, 0, Z,      1, 1, 1, 0,  1, 0, mk(4),  0, 0));
    tbl.push_back(v(0, 0, Z,      1, 0, 0, 0,  1, 1, mk(4),  0, 0));
    // response valid without ready is not a handshake; then two responses
    tbl.push_back(v(0, 0, Z,      0, 1, 0, 0,  1, 0, Z,      0, 0));
    tbl.push_back(v(0, 0, Z,      0, 1, 1, 0,  1, 0, Z,      0, 0));
    tbl.push_back(v(0, 0, Z,      0, 1, 1, 0,  1, 0, Z,      0, 0));
    // reconfig with 2 outstanding
    tbl.push_back(v(0, 1, mk(5),  1, 0, 0, 0,  1, 0, Z,      0, 0));
    tbl.push_back(v(0, 0, Z,      1, 0, 0, 1,  1, 0, mk(5),  0, 0));
    tbl.push_back(v(0, 0, Z,      1, 0, 0, 1,  1, 0, mk(5),  0, 1));
    tbl.push_back(v(0, 0, Z,      1, 1, 1, 1,  1, 0, mk(5),  0, 1));
    tbl.push_back(v(0, 0, Z,      1, 1, 1, 1,  1, 0, mk(5),  0, 1));
    tbl.push_back(v(0, 0, Z,      1, 0, 0, 1,  1, 0, mk(5),  1, 1));
    tbl.push_back(v(0, 0, Z,      1, 0, 0, 1,  1, 0, mk(5),  1, 1));
    tbl.push_back(v(0, 0, Z,      1, 0, 0, 1,  1, 1, mk(5),  1, 0));
    tbl.push_back(v(0, 0, Z,      0, 1, 1, 1,  1, 0, Z,      1, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("v%0d", i));
    end

    // Mode 1 -> 0, then back to 1 while in SWITCH: two full passes,
    // queued request held until the final RUN.
    apply(v(0, 1, mk(6),  1, 0, 0, 0,  1, 0, Z,      1, 0), "sw0");
    apply(v(0, 0, Z,      1, 0, 0, 0,  1, 0, mk(6),  1, 1), "sw1");
    apply(v(0, 0, Z,      1, 0, 0, 1,  1, 0, mk(6),  0, 1), "sw2");
    apply(v(0, 0, Z,      1, 0, 0, 1,  1, 0, mk(6),  0, 1), "sw3");
    apply(v(0, 0, Z,      1, 0, 0, 1,  1, 0, mk(6),  0, 0), "sw4");
    apply(v(0, 0, Z,      1, 0, 0, 1,  1, 0, mk(6),  0, 1), "sw5");
    apply(v(0, 0, Z,      1, 0, 0, 1,  1, 0, mk(6),  1, 1), "sw6");
    apply(v(0, 0, Z,      1, 0, 0, 1,  1, 0, mk(6),  1, 1), "sw7");
    apply(v(0, 0, Z,      1, 0, 0, 1,  1, 1, mk(6),  1, 0), "sw8");

    // Reset while draining with 2 outstanding, then a stray response.
    apply(v(0, 1, mk(7),  1, 0, 0, 1,  1, 0, Z,      1, 0), "rs0");
    apply(v(0, 0, Z,      1, 0, 0, 1,  1, 1, mk(7),  1, 0), "rs1");
    apply(v(0, 1, mk(8),  1, 0, 0, 0,  1, 0, Z,      1, 0), "rs2");
    apply(v(0, 0, Z,      1, 0, 0, 0,  1, 0, mk(8),  1, 1), "rs3");
    apply(v(1, 0, Z,      1, 0, 0, 0,  0, 0, Z,      1, 0), "rs4");
    apply(v(0, 0, Z,      0, 1, 1, 0,  1, 0, Z,      0, 0), "rs5");
`ifdef CACHE_REQ_FRONTEND_STATS_EN
    chk("rs5.stat_req_count",    76'(stat_req_count),    76'(0));
    chk("rs5.stat_drain_cycles", 76'(stat_drain_cycles), 76'(0));
`endif
    // A wrapped counter would block this dispatch.
    apply(v(0, 1, mk(9),  0, 0, 0, 0,  1, 0, Z,      0, 0), "rs6");
    apply(v(0, 0, Z,      0, 0, 0, 0,  1, 1, mk(9),  0, 0), "rs7");
    apply(v(0, 0, Z,      1, 0, 0, 0,  1, 1, mk(9),  0, 0), "rs8");
    apply(v(0, 0, Z,      0, 0, 0, 0,  1, 0, Z,      0, 0), "rs9");
`ifdef CACHE_REQ_FRONTEND_STATS_EN
    chk("rs9.stat_req_count",    76'(stat_req_count),    76'(1));
    chk("rs9.stat_drain_cycles", 76'(stat_drain_cycles), 76'(0));
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
